regfile_multiport: RTL and testbench

- Parametrised register file; successor to the fixed 16:1 32-bit read multiplexer in CPU/RegisterFile.
- Storage, one synchronous write port and NUM_RD independent read ports in one block.
- Read ports have optional write-to-read bypass, an optional PC-alias register and optional registered outputs with a valid strobe.
- Sits between decode (read addresses) and writeback (write port) in the CPU datapath.

---
 rtl/regfile_multiport.sv | 93 +++++++++
 tb/tb_regfile_multiport.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_multiport.sv
// Multi-port register file: one synchronous write port, NUM_RD read ports with
// optional write-to-read bypass, PC-alias register and registered outputs.
module regfile_multiport #(
  parameter int N         = 32,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int NUM_RD    = 2,
  parameter int BYPASS    = 1,
  parameter int PC_MODE   = 1,
  parameter int PC_OFFSET = 8,
  parameter int REG_OUT   = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     we_i,
  input  logic [ADDR_W-1:0]        wa_i,
  input  logic [N-1:0]             wd_i,
  input  logic [NUM_RD-1:0]        re_i,
  input  logic [NUM_RD*ADDR_W-1:0] ra_i,
  input  logic [N-1:0]             pc_i,
  output logic [NUM_RD*N-1:0]      rd_o,
  output logic [NUM_RD-1:0]        rd_valid_o
);

  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(DEPTH - 1);

  logic [N-1:0] regs [DEPTH];
  logic         wa_in_range;
  logic         write_ok;
  logic [N-1:0] pc_value;

  // The top register belongs to the PC when aliased, so writes to it are dropped.
  assign wa_in_range = (32'(wa_i) < DEPTH);
  assign write_ok    = rst_n_i && we_i && wa_in_range &&
                       !((PC_MODE != 0) && (wa_i == PC_ADDR));
  assign pc_value    = pc_i + N'(PC_OFFSET);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (write_ok) begin
      regs[wa_i] <= wd_i;
    end
  end

  // rd_valid_o[k] qualifies rd_o port k; there is no back-pressure, a request
  // is always accepted and its data is valid for exactly one cycle.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_port
    logic [ADDR_W-1:0] ra;
    logic              ra_in_range;
    logic [N-1:0]      read_value;

    assign ra          = ra_i[k*ADDR_W +: ADDR_W];
    assign ra_in_range = (32'(ra) < DEPTH);

    always_comb begin
      read_value = regs[ra_in_range ? ra : ADDR_W'(0)];
      if ((PC_MODE != 0) && (ra == PC_ADDR)) begin
        read_value = pc_value;
      end else if (!ra_in_range) begin
        read_value = '0;
      end else if ((BYPASS != 0) && write_ok && (wa_i == ra)) begin
        read_value = wd_i;
      end
    end

    if (REG_OUT != 0) begin : g_reg
      logic [N-1:0] data_q;
      logic         valid_q;

      always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
          data_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= re_i[k];
          if (re_i[k]) begin
            data_q <= read_value;
          end
        end
      end

      assign rd_o[k*N +: N] = data_q;
      assign rd_valid_o[k]  = valid_q;
    end else begin : g_comb
      assign rd_o[k*N +: N] = read_value;
      assign rd_valid_o[k]  = re_i[k];
    end
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: three configurations share one stimulus stream
// and are checked against a behavioural model through expected-data queues.
module tb_regfile_multiport;

  localparam int N = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] wa = '0;
  logic [N-1:0]  wd = '0;
  logic [1:0]    re = '0;
  logic [2*AW-1:0] ra = '0;
  logic [N-1:0]  pc = '0;

  logic [2*N-1:0] rd_a, rd_b, rd_c;
  logic [1:0]     vld_a, vld_b, vld_c;

  int n_checks = 0;
  int n_fail = 0;

  // Instance 0: defaults. 1: no bypass. 2: DEPTH=12, no PC alias, combinational.
  logic [N-1:0] mem [3][16];
  logic [N-1:0] exp_q [4][$];
  logic [N-1:0] last_val [4];
  logic [1:0]   exp_valid [2];

  always #5 clk = ~clk;

  regfile_multiport dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .we_i(we), .wa_i(wa), .wd_i(wd), .re_i(re),
    .ra_i(ra), .pc_i(pc), .rd_o(rd_a), .rd_valid_o(vld_a)
  );

  regfile_multiport #(.BYPASS(0)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .we_i(we), .wa_i(wa), .wd_i(wd), .re_i(re),
    .ra_i(ra), .pc_i(pc), .rd_o(rd_b), .rd_valid_o(vld_b)
  );

  regfile_multiport #(.DEPTH(12), .PC_MODE(0), .REG_OUT(0)) dut_c (
    .clk_i(clk), .rst_n_i(rst_n), .we_i(we), .wa_i(wa), .wd_i(wd), .re_i(re),
    .ra_i(ra), .pc_i(pc), .rd_o(rd_c), .rd_valid_o(vld_c)
  );

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int cfg_depth(input int inst);
    return (inst == 2) ? 12 : 16;
  endfunction

  function automatic bit cfg_pc(input int inst);
    return inst != 2;
  endfunction

  function automatic bit cfg_bypass(input int inst);
    return inst != 1;
  endfunction

  function automatic bit model_write_ok(input int inst);
    return rst_n && we && (int'(wa) < cfg_depth(inst)) &&
           !(cfg_pc(inst) && int'(wa) == cfg_depth(inst) - 1);
  endfunction

  function automatic logic [N-1:0] model_read(input int inst, input logic [AW-1:0] a);
    if (cfg_pc(inst) && int'(a) == cfg_depth(inst) - 1) return pc + 32'd8;
    if (int'(a) >= cfg_depth(inst)) return '0;
    if (cfg_bypass(inst) && model_write_ok(inst) && wa == a) return wd;
    return mem[inst][a];
  endfunction

  function automatic logic [N-1:0] port_data(input int inst, input int k);
    case (inst)
      0:       return rd_a[k*N +: N];
      1:       return rd_b[k*N +: N];
      default: return rd_c[k*N +: N];
    endcase
  endfunction

  // One clock of stimulus: drive after negedge, check comb outputs, then
  // check registered outputs just after the rising edge.
  task automatic step(input logic r, input logic w, input logic [AW-1:0] a,
                      input logic [N-1:0] d, input logic [1:0] rq,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [N-1:0] p);
    logic [N-1:0] v;
    logic [AW-1:0] addr;
    bit wr_ok [3];
    @(negedge clk);
    rst_n = r; we = w; wa = a; wd = d; re = rq; ra = {a1, a0}; pc = p;
    #1;
    for (int inst = 0; inst < 3; inst++) begin
      wr_ok[inst] = model_write_ok(inst);
      for (int k = 0; k < 2; k++) begin
        addr = (k == 0) ? a0 : a1;
        v = model_read(inst, addr);
        if (inst == 2) begin
          check($sformatf("c_rd%0d", k), port_data(2, k), v);
        end else if (r && rq[k]) begin
          exp_q[inst*2+k].push_back(v);
        end
      end
      if (inst < 2) exp_valid[inst] = r ? rq : 2'b00;
    end
    check("c_valid", {30'd0, vld_c}, {30'd0, rq});
    @(posedge clk);
    for (int inst = 0; inst < 3; inst++) begin
      if (!r) begin
        for (int i = 0; i < 16; i++) mem[inst][i] = '0;
      end else if (wr_ok[inst]) begin
        mem[inst][a] = d;
      end
    end
    #1;
    for (int inst = 0; inst < 2; inst++) begin
      check($sformatf("%s_valid", inst == 0 ? "a" : "b"),
            {30'd0, (inst == 0) ? vld_a : vld_b}, {30'd0, exp_valid[inst]});
      for (int k = 0; k < 2; k++) begin
        if (!r) begin
          last_val[inst*2+k] = '0;
        end else if (exp_valid[inst][k]) begin
          if (exp_q[inst*2+k].size() == 0) begin
            check("queue_underflow", 32'd1, 32'd0);
          end else begin
            last_val[inst*2+k] = exp_q[inst*2+k].pop_front();
          end
        end
        check($sformatf("%s_rd%0d", inst == 0 ? "a" : "b", k),
              port_data(inst, k), last_val[inst*2+k]);
      end
    end
  endtask

  task automatic idle();
    step(1'b1, 1'b0, '0, '0, 2'b00, '0, '0, pc);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) last_val[i] = '0;
    for (int inst = 0; inst < 3; inst++)
      for (int i = 0; i < 16; i++) mem[inst][i] = '0;

    // Reset: registered outputs must come up cleared
    step(1'b0, 1'b1, 4'd1, 32'h1111_1111, 2'b11, 4'd1, 4'd2, 32'h0);
    step(1'b0, 1'b0, '0, '0, 2'b00, '0, '0, 32'h0);

    // Write then read the next cycle
    step(1'b1, 1'b1, 4'd3, 32'hDEAD_BEEF, 2'b00, '0, '0, 32'h0);
    step(1'b1, 1'b0, '0, '0, 2'b01, 4'd3, 4'd0, 32'h0);
    idle();
    check("a_deadbeef", rd_a[N-1:0], 32'hDEAD_BEEF);

    // Same-cycle bypass (dut_b returns the old value)
    step(1'b1, 1'b1, 4'd5, 32'h1234_5678, 2'b11, 4'd5, 4'd6, 32'h0);
    idle();
    check("a_bypass", rd_a[N-1:0], 32'h1234_5678);
    check("b_nobypass", rd_b[N-1:0], 32'h0);

    // PC alias, write to alias dropped, wrap-around
    step(1'b1, 1'b0, '0, '0, 2'b10, '0, 4'd15, 32'h0000_0100);
    step(1'b1, 1'b1, 4'd15, 32'hFFFF_FFFF, 2'b00, '0, '0, 32'h0000_0100);
    step(1'b1, 1'b0, '0, '0, 2'b10, '0, 4'd15, 32'h0000_0100);
    idle();
    check("a_pc_alias", rd_a[2*N-1:N], 32'h0000_0108);
    step(1'b1, 1'b0, '0, '0, 2'b10, '0, 4'd15, 32'hFFFF_FFFC);
    idle();
    check("a_pc_wrap", rd_a[2*N-1:N], 32'h0000_0004);

    // Reset mid-operation with a read pending
    for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 4'(i), 32'(i), 2'b00, '0, '0, 32'h0);
    step(1'b0, 1'b0, '0, '0, 2'b11, 4'd4, 4'd9, 32'h0);
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0, '0, '0, 2'b11, 4'(i), 4'(14 - i), 32'h0);
    idle();

    // Throughput sweep
    for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 4'(i), 32'hA000_0000 + 32'(i), 2'b00, '0, '0, 32'h40);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, '0, '0, 2'b11, 4'(i), 4'(15 - i), 32'h40);
    idle();

    // Out-of-range address on the 12-deep instance
    step(1'b1, 1'b1, 4'd13, 32'h0000_00AA, 2'b00, '0, '0, 32'h0);
    step(1'b1, 1'b1, 4'd11, 32'h0000_0055, 2'b11, 4'd13, 4'd11, 32'h0);
    check("c_oob_read", rd_c[N-1:0], 32'h0);
    check("c_bypass_11", rd_c[2*N-1:N], 32'h0000_0055);
    step(1'b1, 1'b0, '0, '0, 2'b11, 4'd13, 4'd11, 32'h0);
    check("c_last_11", rd_c[2*N-1:N], 32'h0000_0055);

    // Random traffic with occasional resets
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 39) != 0), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), $urandom(), 2'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom());
    end
    idle();

    for (int i = 0; i < 4; i++) check($sformatf("drain%0d", i), 32'(exp_q[i].size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
